// File: rtl/fib_disp_pkg.sv
// Shared types and seven-segment glyph constants for the Fibonacci result display.
package fib_disp_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BCD_W  = 4;
  localparam int unsigned SSEG_W = 8;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_BUSY  = 2'd1,
    ST_SHOW  = 2'd2,
    ST_OFLOW = 2'd3
  } state_t;

  // Active-low {dp,g,f,e,d,c,b,a}; the decimal point is always off.
  localparam logic [SSEG_W-1:0] SSEG_BLANK = 8'hFF;
  localparam logic [SSEG_W-1:0] SSEG_DASH  = 8'hBF;
  localparam logic [SSEG_W-1:0] SSEG_E     = 8'h86;

  localparam logic [SSEG_W-1:0] SSEG_DIGIT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

endpackage

// File: rtl/fib_disp_bcd_to_sseg.sv
// Maps one latched digit to its segment code; non-decimal values show 'E'.
module bcd_to_sseg
  import fib_disp_pkg::*;
(
  input  logic [BCD_W-1:0]  value,
  input  logic              blank,
  output logic [SSEG_W-1:0] sseg_c
);

  always_comb begin
    sseg_c = SSEG_BLANK;
    if (!blank) begin
      if (value <= BCD_W'(9)) begin
        sseg_c = SSEG_DIGIT[value];
      end else begin
        sseg_c = SSEG_E;
      end
    end
  end

endmodule

// File: rtl/fib_disp.sv
// Four-digit multiplexed display of the Fibonacci generator status and result.
module fib_disp
  import fib_disp_pkg::*;
#(
  parameter int unsigned N_REFRESH = 18
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_done,
  input  logic              i_overflow,
  input  logic [BCD_W-1:0]  i_bcd3,
  input  logic [BCD_W-1:0]  i_bcd2,
  input  logic [BCD_W-1:0]  i_bcd1,
  input  logic [BCD_W-1:0]  i_bcd0,
  output logic [DIGITS-1:0] o_an,
  output logic [SSEG_W-1:0] o_sseg
);

  state_t                        state;
  state_t                        state_next;
  logic                          latch_c;
  logic [N_REFRESH-1:0]          cnt;
  logic [DIGITS-1:0][BCD_W-1:0]  digits;
  logic [1:0]                    idx;
  logic [DIGITS-1:0]             blank_mask;
  logic                          above_zero;
  logic [SSEG_W-1:0]             show_sseg;
  logic [SSEG_W-1:0]             glyph_c;
  logic [DIGITS-1:0]             an_c;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_BLANK;
    end else begin
      state <= state_next;
    end
  end

  // Start always wins over done, so a simultaneous pair never latches.
  always_comb begin
    state_next = state;
    latch_c    = 1'b0;
    if (i_start) begin
      state_next = ST_BUSY;
    end else if (i_done) begin
      if (i_overflow) begin
        state_next = ST_OFLOW;
      end else begin
        state_next = ST_SHOW;
        latch_c    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      digits <= '0;
    end else begin
      cnt <= cnt + N_REFRESH'(1);
      if (latch_c) begin
        digits <= {i_bcd3, i_bcd2, i_bcd1, i_bcd0};
      end
    end
  end

  assign idx = cnt[N_REFRESH-1 -: 2];

  // A digit is blanked when it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    blank_mask = '0;
    above_zero = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      above_zero    = above_zero && (digits[k] == '0);
      blank_mask[k] = above_zero;
    end
  end

  bcd_to_sseg u_bcd_to_sseg (
    .value  (digits[idx]),
    .blank  (blank_mask[idx]),
    .sseg_c (show_sseg)
  );

  always_comb begin
    glyph_c = SSEG_BLANK;
    case (state)
      ST_BLANK: glyph_c = SSEG_BLANK;
      ST_BUSY:  glyph_c = SSEG_DASH;
      ST_OFLOW: glyph_c = (idx == 2'd3) ? SSEG_E : SSEG_DASH;
      ST_SHOW:  glyph_c = show_sseg;
      default:  glyph_c = SSEG_BLANK;
    endcase
  end

  assign an_c = ~(DIGITS'(1) << idx);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_an   <= '1;
      o_sseg <= SSEG_BLANK;
    end else begin
      o_an   <= an_c;
      o_sseg <= {1'b1, glyph_c[SSEG_W-2:0]};
    end
  end

endmodule
